// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the fetch-side PC redirect unit.
package pc_redirect_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Width needed to hold a flush count in the range 0..flush_cycles.
  function automatic int flush_cnt_width(input int flush_cycles);
    return $clog2(flush_cycles + 1);
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Instruction-memory fetch handshake between the PC redirect unit and imem.
interface pc_redirect_unit_if;
  import pc_redirect_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);

endinterface

// File: rtl/pc_redirect_unit_flush_counter.sv
// Loadable down-counter that times how long the squash window stays open.
module flush_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register; reset clears any flush window in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the fetch PC: applies branch/jump redirects, drives the imem fetch
// handshake and raises flush to squash wrong-path instructions.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2            // must be >= 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                br_valid,
  input  logic                PCSel,
  input  logic [XLEN-1:0]     target,
  input  logic                stall,
  pc_redirect_unit_if.master  imem,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                fetch_valid,
  output logic                flush,
  output logic                misalign
);

  localparam int             CNT_W    = flush_cnt_width(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  logic            redir_s, good_redir_s, bad_redir_s, advance_s;
  logic [XLEN-1:0] eff_target_s;
  logic            cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CNT_W-1:0] cnt_value_s;

  // Redirects only act while fetching: in FLUSH they come from squashed
  // instructions, and in BOOT nothing has been fetched yet.
  assign redir_s      = br_valid & PCSel & (state_q == FETCH);
  assign good_redir_s = redir_s & ~target[1];
  assign bad_redir_s  = redir_s &  target[1];
  assign eff_target_s = target & 32'hFFFF_FFFE;   // JALR clears bit 0
  assign advance_s    = imem.imem_ready & ~stall;

  flush_counter #(.W(CNT_W)) u_flush_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_s),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec_s),
    .value_o    (cnt_value_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state, next-PC and misalign flag; redirect outranks stall and ready.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (good_redir_s) begin
          pc_d       = eff_target_s;
          cnt_load_s = 1'b1;
          state_d    = (FLUSH_CYCLES > 1) ? FLUSH : FETCH;
        end else begin
          misalign_d = bad_redir_s;
          if (advance_s) begin
            pc_d = pc_q + PC_STEP;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      FLUSH: begin
        cnt_dec_s = 1'b1;
        if (advance_s) begin
          pc_d = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
        // Last flush cycle when the count is about to hit zero; a zero
        // count here is unexpected and simply ends the window.
        if (cnt_zero_s || (cnt_value_s == CNT_ONE)) begin
          state_d = FETCH;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and misalign registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.imem_req  = (state_q != BOOT);
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + PC_STEP;
  assign flush          = good_redir_s | (state_q == FLUSH);
  assign misalign       = misalign_q;
  assign fetch_valid    = (state_q != BOOT) & imem.imem_ready & ~stall & ~flush;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed scoreboard bench for pc_redirect_unit (RESET_PC=0x100, 2 flush cycles).
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic        PCSel;
  logic [31:0] target;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        misalign;

  pc_redirect_unit_if imem_if ();

  pc_redirect_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_valid    (br_valid),
    .PCSel       (PCSel),
    .target      (target),
    .stall       (stall),
    .imem        (imem_if),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        fl;
    logic        fv;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, queue what that cycle
  // must show, then pop and compare well before the next rising edge.
  task automatic step(input string tag, input logic rn, input logic bv, input logic sel,
                      input logic [31:0] tgt, input logic st, input logic rdy,
                      input logic [31:0] e_pc, input logic e_req, input logic e_fl,
                      input logic e_fv, input logic e_mis);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n              = rn;
    br_valid           = bv;
    PCSel              = sel;
    target             = tgt;
    stall              = st;
    imem_if.imem_ready = rdy;
    e.pc  = e_pc;
    e.req = e_req;
    e.fl  = e_fl;
    e.fv  = e_fv;
    e.mis = e_mis;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    chk({tag, ".pc"},    pc,                 got.pc);
    chk({tag, ".addr"},  imem_if.imem_addr,  got.pc);
    chk({tag, ".plus4"}, pc_plus4,           got.pc + 32'd4);
    chk({tag, ".req"},   {31'd0, imem_if.imem_req}, {31'd0, got.req});
    chk({tag, ".flush"}, {31'd0, flush},       {31'd0, got.fl});
    chk({tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, got.fv});
    chk({tag, ".mis"},   {31'd0, misalign},    {31'd0, got.mis});
  endtask

  initial begin
    rst_n              = 1'b0;
    br_valid           = 1'b0;
    PCSel              = 1'b0;
    target             = 32'd0;
    stall              = 1'b0;
    imem_if.imem_ready = 1'b1;

    //    tag        rn    bv    sel   target          st    rdy   pc             req   fl    fv    mis
    step("reset",    1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step("boot",     1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step("f100",     1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b0);
    step("f104",     1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b1, 1'b0);
    step("f108",     1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0108, 1'b1, 1'b0, 1'b1, 1'b0);
    // taken branch at 0x10C; PCSel during FLUSH is ignored
    step("br10c",    1'b1, 1'b1, 1'b1, 32'h0000_0200,  1'b0, 1'b1, 32'h0000_010C, 1'b1, 1'b1, 1'b0, 1'b0);
    step("fl200",    1'b1, 1'b1, 1'b1, 32'h0000_0500,  1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 1'b0);
    step("f204",     1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0204, 1'b1, 1'b0, 1'b1, 1'b0);
    // JALR odd target clears bit 0
    step("jalr301",  1'b1, 1'b1, 1'b1, 32'h0000_0301,  1'b0, 1'b1, 32'h0000_0208, 1'b1, 1'b1, 1'b0, 1'b0);
    step("fl300",    1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 1'b0);
    // misaligned target: no flush, sequential PC, misalign one cycle later
    step("jalr302",  1'b1, 1'b1, 1'b1, 32'h0000_0302,  1'b0, 1'b1, 32'h0000_0304, 1'b1, 1'b0, 1'b1, 1'b0);
    step("mis308",   1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0308, 1'b1, 1'b0, 1'b1, 1'b1);
    step("f30c",     1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_030C, 1'b1, 1'b0, 1'b1, 1'b0);
    // memory wait at 0x40
    step("br40",     1'b1, 1'b1, 1'b1, 32'h0000_0040,  1'b0, 1'b1, 32'h0000_0310, 1'b1, 1'b1, 1'b0, 1'b0);
    step("wait1",    1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 1'b0);
    step("wait2",    1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    step("wait3",    1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rdy40",    1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0);
    // stall together with redirect: redirect wins
    step("stbr80",   1'b1, 1'b1, 1'b1, 32'h0000_0080,  1'b1, 1'b1, 32'h0000_0044, 1'b1, 1'b1, 1'b0, 1'b0);
    step("fl80",     1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 1'b0);
    step("stall1",   1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0084, 1'b1, 1'b0, 1'b0, 1'b0);
    step("stall2",   1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0084, 1'b1, 1'b0, 1'b0, 1'b0);
    step("unstall",  1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0084, 1'b1, 1'b0, 1'b1, 1'b0);
    // wrap at the top of the address space
    step("brtop",    1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC,  1'b0, 1'b1, 32'h0000_0088, 1'b1, 1'b1, 1'b0, 1'b0);
    step("fltop",    1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
    step("wrap0",    1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    // reset asserted while in FLUSH takes effect immediately
    step("br600",    1'b1, 1'b1, 1'b1, 32'h0000_0600,  1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1'b0);
    step("rstfl",    1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step("reboot",   1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step("refetch",  1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b0);
    step("seq104",   1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b1, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
